// File: rtl/x86_defs.sv
// Shared definitions for the x86 front end.
//   ADDR_W       : width of a real-mode linear address (20 bits)
//   RESET_VECTOR : linear address of F000:FFF0, the first fetch after reset
//   lin_addr_t   : linear address type
//   addr_inc     : next linear address, wrapping FFFFF -> 00000
package x86_defs;

    localparam int unsigned ADDR_W = 20;

    typedef logic [ADDR_W-1:0] lin_addr_t;

    localparam lin_addr_t RESET_VECTOR = 20'hFFFF0;

    // Unsigned overflow of the 20-bit type gives the real-mode wrap.
    function automatic lin_addr_t addr_inc(input lin_addr_t a);
        return a + lin_addr_t'(1);
    endfunction

endpackage

// File: rtl/x86_prefetch_if.sv
// Bus bundle between the prefetch queue, code memory and the decoder.
//   address/rd      : registered memory read request (prefetch -> memory)
//   i_data          : memory read data, one edge after the request
//   flush/flush_addr: restart request from the execution unit
//   q_data/q_addr   : head byte and its linear address
//   q_valid/q_count : queue non-empty flag and occupancy
//   q_pop           : decoder consumes the head byte
// master = prefetch queue side, slave = memory/decoder/control side.
interface x86_prefetch_if
    import x86_defs::*;
#(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    lin_addr_t      address;
    logic           rd;
    logic [7:0]     i_data;
    logic           flush;
    lin_addr_t      flush_addr;
    logic [7:0]     q_data;
    lin_addr_t      q_addr;
    logic           q_valid;
    logic           q_pop;
    logic [CW-1:0]  q_count;

    modport master (
        output address, rd, q_data, q_addr, q_valid, q_count,
        input  i_data, flush, flush_addr, q_pop
    );

    modport slave (
        input  address, rd, q_data, q_addr, q_valid, q_count,
        output i_data, flush, flush_addr, q_pop
    );

endinterface

// File: rtl/x86_pfq_fifo.sv
// Byte FIFO backing the prefetch queue.
//   clock, reset : clock, async active-high reset (pointers/count only)
//   en           : cycle enable; nothing changes when low
//   clear        : empty the queue (takes precedence over push/pop)
//   push, wdata  : write a byte at the tail
//   pop          : advance the head; caller guarantees count != 0
//   rdata        : head byte (don't-care when empty)
//   count        : occupancy, 0..DEPTH
module x86_pfq_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (en) begin
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PW'(1);
                if (pop)  head <= head + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (en && push && !clear) mem[tail] <= wdata;
    end

    assign rdata = mem[head];

endmodule

// File: rtl/x86_prefetch.sv
// Instruction prefetch queue feeding the opcode/prefix decoder.
//   clock  : system clock
//   reset  : asynchronous active-high reset
//   locked : global cycle enable; all state holds when low
//   bus    : memory request/data, flush control and decoder queue port
// A single outstanding read: rd doubles as the "read in flight" flag, and
// is only raised when the queue has room for the byte returning next edge.
module x86_prefetch
    import x86_defs::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter lin_addr_t   RESET_ADDR = RESET_VECTOR
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            locked,
    x86_prefetch_if.master  bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    lin_addr_t     addr_r;
    lin_addr_t     qaddr_r;
    logic          rd_r;
    logic [CW-1:0] count;
    logic          pop_ok;
    logic [CW-1:0] count_after;

    // Pops on an empty queue are dropped here so the FIFO never underflows.
    assign pop_ok      = bus.q_pop && (count != '0);
    assign count_after = count + CW'(rd_r) - CW'(pop_ok);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_r  <= RESET_ADDR;
            qaddr_r <= RESET_ADDR;
            rd_r    <= 1'b0;
        end else if (locked) begin
            if (bus.flush) begin
                addr_r  <= bus.flush_addr;
                qaddr_r <= bus.flush_addr;
                rd_r    <= 1'b1;
            end else begin
                if (rd_r)   addr_r  <= addr_inc(addr_r);
                if (pop_ok) qaddr_r <= addr_inc(qaddr_r);
                rd_r <= (count_after < CW'(DEPTH));
            end
        end
    end

    x86_pfq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .en    (locked),
        .clear (bus.flush),
        .push  (rd_r && !bus.flush),
        .wdata (bus.i_data),
        .pop   (pop_ok && !bus.flush),
        .rdata (bus.q_data),
        .count (count)
    );

    assign bus.address = addr_r;
    assign bus.rd      = rd_r;
    assign bus.q_addr  = qaddr_r;
    assign bus.q_count = count;
    assign bus.q_valid = (count != '0);

endmodule

// File: tb/tb_x86_prefetch.sv
// Self-checking bench for x86_prefetch: memory returns the low byte of the
// requested address; a scoreboard of expected head addresses is loaded on
// every flush/reset and checked each time the decoder side pops.
module tb_x86_prefetch;
    import x86_defs::*;

    localparam int unsigned DEPTH = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       locked;
    logic       junk_en;
    logic [7:0] junk;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    lin_addr_t   sb[$];

    x86_prefetch_if #(.DEPTH(DEPTH)) bus ();

    x86_prefetch #(
        .DEPTH      (DEPTH),
        .RESET_ADDR (20'hFFFF0)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .locked (locked),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] mem_byte(input lin_addr_t a);
        return a[7:0];
    endfunction

    assign bus.i_data = junk_en ? junk : mem_byte(bus.address);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic exp_rd, input lin_addr_t exp_addr,
                               input lin_addr_t exp_qaddr, input int unsigned exp_count);
        check_val({tag, ".rd"},      32'(bus.rd),      32'(exp_rd));
        check_val({tag, ".address"}, 32'(bus.address), 32'(exp_addr));
        check_val({tag, ".q_addr"},  32'(bus.q_addr),  32'(exp_qaddr));
        check_val({tag, ".q_count"}, 32'(bus.q_count), exp_count);
    endtask

    task automatic sb_load(input lin_addr_t start, input int n);
        sb.delete();
        for (int i = 0; i < n; i++) sb.push_back(start + lin_addr_t'(i));
    endtask

    // Called at a negedge: if the coming edge pops, compare the head first.
    task automatic step();
        lin_addr_t e;
        if (locked && !reset && !bus.flush && bus.q_pop && bus.q_valid) begin
            check_val("sb_nonempty", 32'(sb.size() != 0), 32'h1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_val("head_addr", 32'(bus.q_addr), 32'(e));
                check_val("head_data", 32'(bus.q_data), 32'(mem_byte(e)));
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        locked         = 1'b1;
        junk_en        = 1'b0;
        junk           = 8'h00;
        bus.flush      = 1'b0;
        bus.flush_addr = '0;
        bus.q_pop      = 1'b0;

        // reset and first fill
        repeat (2) @(negedge clock);
        check_state("rst", 1'b0, 20'hFFFF0, 20'hFFFF0, 0);
        check_val("rst.q_valid", 32'(bus.q_valid), 32'h0);
        reset     = 1'b0;
        bus.q_pop = 1'b1;
        sb_load(20'hFFFF0, 8);
        step();
        check_state("first_issue", 1'b1, 20'hFFFF0, 20'hFFFF0, 0);
        bus.q_pop = 1'b0;
        step();
        check_val("first.q_valid", 32'(bus.q_valid), 32'h1);
        check_val("first.q_data",  32'(bus.q_data),  32'hF0);
        check_state("first", 1'b1, 20'hFFFF1, 20'hFFFF0, 1);
        repeat (6) step();
        check_state("fill7", 1'b1, 20'hFFFF7, 20'hFFFF0, 7);
        step();
        check_state("full", 1'b0, 20'hFFFF8, 20'hFFFF0, 8);
        step();
        check_state("full_idle", 1'b0, 20'hFFFF8, 20'hFFFF0, 8);

        // one pop from full re-raises rd
        bus.q_pop = 1'b1;
        step();
        bus.q_pop = 1'b0;
        check_state("pop_full", 1'b1, 20'hFFFF8, 20'hFFFF1, 7);
        sb.push_back(20'hFFFF8);
        step();
        check_state("refill", 1'b0, 20'hFFFF9, 20'hFFFF1, 8);

        // streaming across the FFFFF -> 00000 wrap
        bus.flush      = 1'b1;
        bus.flush_addr = 20'hFFFFE;
        bus.q_pop      = 1'b1;
        step();
        bus.flush = 1'b0;
        check_state("flush_full", 1'b1, 20'hFFFFE, 20'hFFFFE, 0);
        sb_load(20'hFFFFE, 32);
        step();
        check_state("stream0", 1'b1, 20'hFFFFF, 20'hFFFFE, 1);
        repeat (5) step();
        check_state("stream_wrap", 1'b1, 20'h00004, 20'h00003, 1);

        // flush while a read is in flight; pop held through the flush
        bus.flush      = 1'b1;
        bus.flush_addr = 20'h01234;
        step();
        bus.flush = 1'b0;
        bus.q_pop = 1'b0;
        check_state("flush_inflight", 1'b1, 20'h01234, 20'h01234, 0);
        check_val("flush_inflight.q_valid", 32'(bus.q_valid), 32'h0);
        sb_load(20'h01234, 32);
        step();
        check_val("after_flush.q_valid", 32'(bus.q_valid), 32'h1);
        check_val("after_flush.q_data",  32'(bus.q_data),  32'h34);
        check_state("after_flush", 1'b1, 20'h01235, 20'h01234, 1);
        repeat (6) step();
        check_state("count7", 1'b1, 20'h0123B, 20'h01234, 7);

        // simultaneous pop and capture at count 7
        bus.q_pop = 1'b1;
        step();
        bus.q_pop = 1'b0;
        check_state("pop_cap7", 1'b1, 20'h0123C, 20'h01235, 7);
        step();
        check_state("full2", 1'b0, 20'h0123D, 20'h01235, 8);

        // flush while full, then pop attempted on the empty queue
        bus.flush      = 1'b1;
        bus.flush_addr = 20'h0ABCD;
        step();
        bus.flush = 1'b0;
        check_state("flush_when_full", 1'b1, 20'h0ABCD, 20'h0ABCD, 0);
        sb_load(20'h0ABCD, 32);
        bus.q_pop = 1'b1;
        step();
        check_state("pop_empty", 1'b1, 20'h0ABCE, 20'h0ABCD, 1);
        step();
        step();
        check_state("stream2", 1'b1, 20'h0ABD0, 20'h0ABCF, 1);
        check_val("stream2.q_data", 32'(bus.q_data), 32'hCF);

        // locked low for three edges with garbage on i_data
        locked  = 1'b0;
        junk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            junk = 8'($urandom);
            step();
            check_state("unlocked", 1'b1, 20'h0ABD0, 20'h0ABCF, 1);
            check_val("unlocked.q_data", 32'(bus.q_data), 32'hCF);
        end
        junk_en = 1'b0;
        locked  = 1'b1;
        step();
        check_state("resume", 1'b1, 20'h0ABD1, 20'h0ABD0, 1);
        check_val("resume.q_data", 32'(bus.q_data), 32'hD0);

        // asynchronous reset between edges mid-fill
        bus.q_pop      = 1'b0;
        bus.flush      = 1'b1;
        bus.flush_addr = 20'h00100;
        step();
        bus.flush = 1'b0;
        repeat (3) step();
        check_state("midfill", 1'b1, 20'h00103, 20'h00100, 3);
        #2 reset = 1'b1;
        #1;
        check_state("async_rst", 1'b0, 20'hFFFF0, 20'hFFFF0, 0);
        check_val("async_rst.q_valid", 32'(bus.q_valid), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        step();
        check_state("rst_issue", 1'b1, 20'hFFFF0, 20'hFFFF0, 0);
        step();
        check_state("rst_first", 1'b1, 20'hFFFF1, 20'hFFFF0, 1);
        check_val("rst_first.q_data", 32'(bus.q_data), 32'hF0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/x86_prefetch.md
# x86_prefetch

Instruction prefetch queue sitting directly upstream of the x86 CPU opcode/prefix decoder. It autonomously reads code bytes from the 20-bit linear address space into a small FIFO, one byte per cycle. It presents the head byte and its linear address to the decoder, which pops bytes as it consumes prefixes, opcode, ModRM and immediates. A flush restarts fetching at a new linear address on jumps, calls, interrupts and segment reloads.

## Interface
Parameters:
- DEPTH, 8: queue entries, power of two, ≥ 2.
- RESET_ADDR, 20'hFFFF0: first fetch address after reset (F000:FFF0).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- locked  in  1  global cycle enable; when 0 the block holds all state.
- address  out  20  linear address of the in-flight read, or the next byte to fetch.
- rd  out  1  memory read strobe (registered).
- i_data  in  8  memory read data, valid at the edge after rd/address are registered.
- flush  in  1  discard queue and in-flight read; restart at flush_addr.
- flush_addr  in  20  new fetch/head linear address.
- q_data  out  8  head byte; valid only when q_valid=1.
- q_addr  out  20  linear address of the head byte.
- q_valid  out  1  queue non-empty.
- q_pop  in  1  consumer takes the head byte this edge.
- q_count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Reset (async) values:
  - rd=0, address=RESET_ADDR, q_addr=RESET_ADDR.
  - q_valid=0, q_count=0, head and tail pointers=0.
  - q_data is don't-care.
- Edges with locked=0 change nothing; flush and q_pop are ignored, so requesters must hold them until a locked edge.
- At each locked edge, in priority order:
  - **Flush:** clear pointers and count, drop any i_data being captured, ignore q_pop. Set address=flush_addr, q_addr=flush_addr, rd=1.
  - **Capture:** if rd=1, write i_data at the tail and set address=address+1. The increment wraps FFFFF→00000.
  - **Pop:** if q_pop=1 and q_count>0, advance the head and set q_addr=q_addr+1 (same wrap). A pop when empty is ignored. The captured byte cannot be popped on its own capture edge.
  - **Issue:** compute count_after = q_count + capture − pop. Set rd = (count_after < DEPTH). This reserves the slot for the byte returning next edge.
- A simultaneous capture and pop leaves the count unchanged. Both pointers wrap modulo DEPTH.
- No internal state machine beyond rd acting as a single "read in flight" flag. At most one read is outstanding.

## Timing
- Memory contract: address and rd are registered at edge N; i_data is sampled at the next locked edge N+1.
- Flush at edge E:
  - address=flush_addr and rd=1 after E.
  - First byte is captured at E+1; q_valid=1 and q_data=mem[flush_addr] after E+1.
- Sustained throughput is 1 byte/cycle when the consumer pops every cycle.
- Filling from empty with no pops:
  - Byte k is captured at E+1+k.
  - rd drops after the edge that captures byte DEPTH−1, i.e. the DEPTH-th byte. This is because count_after then equals DEPTH.
  - address then equals flush_addr+DEPTH.
- Full queue: one pop at edge P re-raises rd after P. The next byte is captured at P+1.
- Reset asserted mid-fetch clears immediately. The first read issues at the first locked edge after release, with address=RESET_ADDR.

## Structure
- Shared package/include x86_defs holds:
  - ADDR_W=20.
  - RESET_VECTOR=20'hFFFF0, which is the default of RESET_ADDR.
- One natural sub-module, x86_pfq_fifo, holds:
  - the storage array (DEPTH×8), head/tail pointers and count;
  - push/pop/clear inputs;
  - head data and count outputs.
- The top level x86_prefetch owns the address/rd/q_addr registers and the flush/issue logic.

## Test plan
- **Reset and first fill:** release reset, locked=1, memory returns low byte of address, no pops → address FFFF0… and q_data=F0 after second edge. rd falls after 8 captures, q_count=8, address=FFFF8.
- **Streaming with wrap:** flush_addr=FFFFE, q_pop held 1 → consumer sees bytes from FFFFE, FFFFF, 00000, 00001 on consecutive cycles. q_addr tracks them.
- **Flush during in-flight read and while full:** flush_addr=01234 → captured byte dropped, q_count=0. The next head is mem[01234] at q_addr=01234 one edge later.
- **Simultaneous pop and capture at full-1 (count=7):** q_count stays 7 and rd stays 1. Pop on empty → ignored, q_count=0.
- **locked=0 for 3 cycles mid-stream** with i_data changing and q_pop=1 → no state change. Resumes exactly where it stopped.
- **Asynchronous reset asserted between edges mid-fill** → outputs take reset values immediately, without a clock edge.
